ps2_key_receiver: RTL and testbench
===================================

// Module: ps2_key_receiver
// PURPOSE
//  Next-generation PS/2 keyboard receiver. Samples kbdClk/kbdDataIn on the system clock
//  and decodes full 11-bit frames. Checks odd parity and the stop bit, times out on
//  stalled frames, and tracks E0 (extended) and F0 (release) prefixes. Queues decoded
//  key events in a FIFO behind a valid/ready handshake to the CPU-side I/O logic.
// PARAMETERS
//  FIFO_DEPTH      16      event FIFO entries; power of 2, >=2
//  SYNC_STAGES     2       input synchroniser flops on kbdClk and kbdDataIn; >=2
//  TIMEOUT_CYCLES  100000  max clk cycles between kbdClk falling edges inside a frame
//  ASCII_EN        1       1: keyAscii from map; 0: keyAscii tied to 8'h00
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rstN         in   1   asynchronous, active-low reset
//  kbdClk       in   1   raw PS/2 clock pin (async)
//  kbdDataIn    in   1   raw PS/2 data pin (async)
//  keyValid     out  1   FIFO head holds an event
//  keyReady     in   1   consumer accepts head when keyValid & keyReady
//  keyCode      out  8   raw scan code of head event
//  keyAscii     out  8   ASCII of head event, 8'h00 if unmapped
//  keyRelease   out  1   head event was preceded by F0
//  keyExtended  out  1   head event was preceded by E0
//  fifoCount    out  $clog2(FIFO_DEPTH)+1  occupied entries
//  parityErr    out  1   1-cycle pulse: frame failed odd parity
//  frameErr     out  1   1-cycle pulse: bad start/stop bit or timeout
//  overflow     out  1   1-cycle pulse: event dropped, FIFO full
// BEHAVIOUR
//  Reset: every output 0, FSM IDLE, prefix flags clear, FIFO empty. Reset asserted
//   mid-frame drops the frame and the FIFO contents.
//  Edge detect: fall = syncClkPrev & ~syncClk, after SYNC_STAGES flops. Data sampled on fall.
//  FSM: IDLE -fall&d=0-> DATA(bitCnt=0). IDLE -fall&d=1-> IDLE, frameErr pulse.
//   DATA: shift LSB-first; after 8th bit -> PARITY. PARITY: ^{data,bit} must be 1,
//   else latch parity fail -> STOP. STOP: d=1 and no parity fail -> frame OK;
//   d=0 -> frameErr; parity fail -> parityErr (never both). Any exit -> IDLE.
//  Timeout: in DATA/PARITY/STOP, a wdog counter resets on each fall. When it reaches
//   TIMEOUT_CYCLES -> IDLE + frameErr; partial frame discarded. Counter idles at 0 in IDLE.
//  Decode (good frames only): E0 -> extPend=1; F0 -> relPend=1; other code -> push
//   {code,ascii,relPend,extPend}, then clear both flags. An errored frame clears both
//   flags and pushes nothing.
//  ASCII map: letters A-Z uppercase (1C=A,32=B,...,1A=Z), digits 0-9 (45=0,16=1,...,46=9),
//   29=" ", 5A=8'h0D, 66=8'h08, 76=8'h1B; all else 8'h00.
//  Latency: push occurs the cycle after the stop-bit fall is detected. keyValid rises
//   the next cycle (registered FIFO, first-word fall-through).
//  FIFO: pop on keyValid&keyReady. Push when full and no pop: event dropped, overflow
//   pulse, contents intact. Push+pop same cycle when full: both accepted, no overflow.
//   Push+pop when empty: push only. Pointers wrap mod FIFO_DEPTH. Head outputs are
//   stable while keyValid & ~keyReady.
// STRUCTURE
//  Package ps2_pkg: state enum {IDLE,DATA,PARITY,STOP}; constants SC_EXT=8'hE0,
//   SC_REL=8'hF0; typedef struct packed key_event_t {code,ascii,release,extended};
//   function scan_to_ascii.
//  Sub-module ps2_event_fifo #(DEPTH, type T): sync FWFT FIFO with count/full/empty.
//  Top: synchroniser, edge detect, FSM, watchdog, prefix decode, output mapping.
// TESTING
//  1 Frame 0x1C, odd parity ok -> one event: code 1C, ascii 41, rel 0, ext 0, count 1.
//  2 E0,F0,75 then F0,1C -> events {75,00,rel1,ext1}, {1C,41,rel1,ext0}; none for prefixes.
//  3 0x1C with parity flipped -> parityErr pulse, no push. Next good 0x16 -> ascii 31.
//  4 Stop bit 0 -> frameErr; 5 bits then stall TIMEOUT_CYCLES -> frameErr, FSM IDLE,
//    following frame decodes.
//  5 keyReady=0, FIFO_DEPTH+1 keys -> count 16, one overflow pulse. Drain -> original order.
//  6 Full FIFO, push+pop same cycle -> no overflow, count 16. rstN low mid-frame -> all 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and helper functions for the PS/2 key receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_REL = 8'hF0;

    // One decoded key event as stored in the event FIFO.
    // The release flag is named 'released' because 'release' is a reserved word.
    typedef struct packed {
        logic [7:0] code;
        logic [7:0] ascii;
        logic       released;
        logic       extended;
    } key_event_t;

    // Odd parity over data plus parity bit: result is 1 when the frame is good.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Scan-code set 2 to ASCII for letters, digits and a few control keys.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08; 8'h76: a = 8'h1B;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_key_receiver_fifo.sv
// Synchronous first-word-fall-through FIFO for decoded key events.
// A push into a full FIFO is only accepted when a pop happens in the same cycle;
// otherwise the event is dropped and a one-cycle overflow pulse is raised.
module ps2_event_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  T                         wr_data,
    input  logic                     rd_en,
    output T                         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    T               mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [AW:0]    count_r;
    logic           overflow_r;
    logic           full_s;
    logic           empty_s;
    logic           do_pop_s;
    logic           do_push_s;

    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign empty_s   = (count_r == (AW+1)'(0));
    assign do_pop_s  = rd_en & ~empty_s;
    assign do_push_s = wr_en & (~full_s | do_pop_s);

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= wr_en & full_s & ~do_pop_s;
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign empty    = empty_s;
    assign overflow = overflow_r;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, decodes 11-bit frames,
// tracks E0/F0 prefixes and queues key events behind a valid/ready interface.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ASCII_EN       = 1
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          kbdClk,
    input  logic                          kbdDataIn,
    output logic                          keyValid,
    input  logic                          keyReady,
    output logic [7:0]                    keyCode,
    output logic [7:0]                    keyAscii,
    output logic                          keyRelease,
    output logic                          keyExtended,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          parityErr,
    output logic                          frameErr,
    output logic                          overflow
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   fall_s;
    logic                   data_s;

    ps2_state_t             state_r;
    ps2_state_t             next_state_s;
    logic [7:0]             shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   par_fail_r;
    logic [WDW-1:0]         wdog_r;
    logic                   timeout_s;
    logic                   frame_ok_s;
    logic                   frame_err_s;
    logic                   parity_err_s;

    logic                   ext_pend_r;
    logic                   rel_pend_r;
    logic                   push_r;
    key_event_t             push_data_r;
    logic                   parity_err_r;
    logic                   frame_err_r;

    key_event_t             head_s;
    logic                   fifo_empty_s;
    logic                   fifo_ovf_s;
    logic                   pop_s;

    // Synchronisers reset low so a pin already high at reset release gives no false fall.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            clk_sync_r  <= {SYNC_STAGES{1'b0}};
            data_sync_r <= {SYNC_STAGES{1'b0}};
            clk_prev_r  <= 1'b0;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], kbdClk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], kbdDataIn};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s    = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign data_s    = data_sync_r[SYNC_STAGES-1];
    assign timeout_s = (state_r != IDLE) && (wdog_r >= WDW'(TIMEOUT_CYCLES));

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Frame FSM next state and frame-result strobes; timeout wins over a coincident fall.
    always_comb begin
        next_state_s = state_r;
        frame_ok_s   = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s && !data_s) begin
                    next_state_s = DATA;
                end else if (fall_s) begin
                    frame_err_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DATA: begin
                if (timeout_s) begin
                    next_state_s = IDLE;
                    frame_err_s  = 1'b1;
                end else if (fall_s && (bit_cnt_r == 3'd7)) begin
                    next_state_s = PARITY;
                end else begin
                    next_state_s = DATA;
                end
            end
            PARITY: begin
                if (timeout_s) begin
                    next_state_s = IDLE;
                    frame_err_s  = 1'b1;
                end else if (fall_s) begin
                    next_state_s = STOP;
                end else begin
                    next_state_s = PARITY;
                end
            end
            STOP: begin
                if (timeout_s) begin
                    next_state_s = IDLE;
                    frame_err_s  = 1'b1;
                end else if (fall_s) begin
                    next_state_s = IDLE;
                    if (par_fail_r) begin
                        parity_err_s = 1'b1;
                    end else if (!data_s) begin
                        frame_err_s = 1'b1;
                    end else begin
                        frame_ok_s = 1'b1;
                    end
                end else begin
                    next_state_s = STOP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and latched parity result for the frame in flight.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            par_fail_r <= 1'b0;
        end else if (fall_s) begin
            case (state_r)
                IDLE: begin
                    bit_cnt_r  <= 3'd0;
                    par_fail_r <= 1'b0;
                end
                DATA: begin
                    shift_r   <= {data_s, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                PARITY: begin
                    par_fail_r <= ~odd_parity_ok(shift_r, data_s);
                end
                default: begin
                    par_fail_r <= par_fail_r;
                end
            endcase
        end
    end

    // Watchdog: counts cycles since the last fall while a frame is open, idles at zero.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wdog_r <= {WDW{1'b0}};
        end else if ((next_state_s == IDLE) || fall_s) begin
            wdog_r <= {WDW{1'b0}};
        end else begin
            wdog_r <= wdog_r + WDW'(1);
        end
    end

    // Prefix tracking, event build and registered error pulses.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ext_pend_r   <= 1'b0;
            rel_pend_r   <= 1'b0;
            push_r       <= 1'b0;
            push_data_r  <= '{code: 8'h00, ascii: 8'h00, released: 1'b0, extended: 1'b0};
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            parity_err_r <= parity_err_s;
            frame_err_r  <= frame_err_s;
            push_r       <= 1'b0;
            if (frame_ok_s) begin
                if (shift_r == SC_EXT) begin
                    ext_pend_r <= 1'b1;
                end else if (shift_r == SC_REL) begin
                    rel_pend_r <= 1'b1;
                end else begin
                    push_r               <= 1'b1;
                    push_data_r.code     <= shift_r;
                    push_data_r.ascii    <= (ASCII_EN != 0) ? scan_to_ascii(shift_r) : 8'h00;
                    push_data_r.released <= rel_pend_r;
                    push_data_r.extended <= ext_pend_r;
                    ext_pend_r           <= 1'b0;
                    rel_pend_r           <= 1'b0;
                end
            end else if (frame_err_s || parity_err_s) begin
                ext_pend_r <= 1'b0;
                rel_pend_r <= 1'b0;
            end else begin
                ext_pend_r <= ext_pend_r;
                rel_pend_r <= rel_pend_r;
            end
        end
    end

    assign pop_s = keyReady & ~fifo_empty_s;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (key_event_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rstN),
        .wr_en    (push_r),
        .wr_data  (push_data_r),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .count    (fifoCount),
        .empty    (fifo_empty_s),
        .overflow (fifo_ovf_s)
    );

    assign keyValid    = ~fifo_empty_s;
    assign keyCode     = keyValid ? head_s.code     : 8'h00;
    assign keyAscii    = keyValid ? head_s.ascii    : 8'h00;
    assign keyRelease  = keyValid ? head_s.released : 1'b0;
    assign keyExtended = keyValid ? head_s.extended : 1'b0;
    assign parityErr   = parity_err_r;
    assign frameErr    = frame_err_r;
    assign overflow    = fifo_ovf_s;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench: drives PS/2 frames, keeps an event-level model of the
// expected key stream and error pulses, and checks every popped event.
module tb_ps2_key_receiver;

    localparam int DEPTH = 16;
    localparam int TMO   = 300;
    localparam int HALF  = 12;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       kbdClk = 1'b1;
    logic       kbdDataIn = 1'b1;
    logic       keyReady = 1'b0;
    logic       keyValid, keyRelease, keyExtended, parityErr, frameErr, overflow;
    logic [7:0] keyCode, keyAscii;
    logic [4:0] fifoCount;
    logic [17:0] head;

    always #5 clk = ~clk;

    ps2_key_receiver #(
        .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO), .ASCII_EN(1)
    ) dut (
        .clk(clk), .rstN(rstN), .kbdClk(kbdClk), .kbdDataIn(kbdDataIn),
        .keyValid(keyValid), .keyReady(keyReady), .keyCode(keyCode), .keyAscii(keyAscii),
        .keyRelease(keyRelease), .keyExtended(keyExtended), .fifoCount(fifoCount),
        .parityErr(parityErr), .frameErr(frameErr), .overflow(overflow)
    );

    assign head = {keyCode, keyAscii, keyRelease, keyExtended};

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};

    int tests = 0;
    int fails = 0;

    logic [17:0] mq[$];
    logic m_ext = 1'b0, m_rel = 1'b0;
    int exp_par = 0, exp_frm = 0, exp_ovf = 0;
    int got_par = 0, got_frm = 0, got_ovf = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_ascii(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (LETTERS[i] == c) return 8'h41 + 8'(i);
        for (int i = 0; i < 10; i++) if (DIGITS[i] == c) return 8'h30 + 8'(i);
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    // kind: 0 good frame, 1 parity flipped, 2 stop bit low
    task automatic model_frame(input logic [7:0] code, input int kind, input bit pop_now);
        if (kind == 1) begin
            exp_par++; m_ext = 1'b0; m_rel = 1'b0;
        end else if (kind == 2) begin
            exp_frm++; m_ext = 1'b0; m_rel = 1'b0;
        end else if (code == 8'hE0) begin
            m_ext = 1'b1;
        end else if (code == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            if (mq.size() >= DEPTH && !pop_now) exp_ovf++;
            else mq.push_back({code, model_ascii(code), m_rel, m_ext});
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        kbdDataIn = b;
        repeat (HALF) @(posedge clk);
        #1 kbdClk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 kbdClk = 1'b1;
    endtask

    // pop_at_stop raises keyReady for exactly the cycle the DUT pushes this frame's event.
    task automatic send_frame(input logic [7:0] code, input int kind, input bit pop_at_stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = code;
        f[9]   = (~^code) ^ (kind == 1);
        f[10]  = (kind == 2) ? 1'b0 : 1'b1;
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        kbdDataIn = f[10];
        repeat (HALF) @(posedge clk);
        #1 kbdClk = 1'b0;
        model_frame(code, kind, pop_at_stop);
        if (pop_at_stop) begin
            repeat (3) @(posedge clk);
            #1 keyReady = 1'b1;
            @(posedge clk);
            #1 keyReady = 1'b0;
            repeat (HALF - 4) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 kbdClk = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(1'(i & 1));
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        keyReady = 1'b1;
        while ((mq.size() != 0 || keyValid) && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
        keyReady = 1'b0;
        check("drain_in_time", (n < 2000), 1);
        settle();
        check("drain_count", fifoCount, 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_parity_pulses"}, got_par, exp_par);
        check({tag, "_frame_pulses"}, got_frm, exp_frm);
        check({tag, "_overflow_pulses"}, got_ovf, exp_ovf);
    endtask

    // Per-cycle compare against the model and pulse-shape rules.
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic prev_p = 1'b0, prev_f = 1'b0, prev_o = 1'b0;
    logic [17:0] prev_head = 18'h0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prev_valid = 1'b0; prev_ready = 1'b0;
                prev_p = 1'b0; prev_f = 1'b0; prev_o = 1'b0;
            end else begin
                if (parityErr) got_par++;
                if (frameErr)  got_frm++;
                if (overflow)  got_ovf++;
                check("pulse_single_cycle", {prev_p & parityErr, prev_f & frameErr, prev_o & overflow}, 0);
                check("never_both_errors", parityErr & frameErr, 0);
                if (prev_valid && !prev_ready) check("head_stable", {keyValid, head}, {1'b1, prev_head});
                if (keyValid && keyReady) begin
                    check("pop_model_nonempty", (mq.size() != 0), 1);
                    if (mq.size() != 0) begin
                        check("pop_event", head, mq[0]);
                        void'(mq.pop_front());
                    end
                end
                prev_valid = keyValid; prev_ready = keyReady; prev_head = head;
                prev_p = parityErr; prev_f = frameErr; prev_o = overflow;
            end
        end
    end

    // Random consumer backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) keyReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ovf0;
        logic [7:0] c;
        int kind;
        repeat (4) @(posedge clk);
        #1;
        check("reset_outputs", {keyValid, keyCode, keyAscii, keyRelease, keyExtended,
                                fifoCount, parityErr, frameErr, overflow}, 0);
        rstN = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // single good frame
        send_frame(8'h1C, 0, 1'b0);
        settle();
        check("t1_model_pin", mq[0], {8'h1C, 8'h41, 1'b0, 1'b0});
        check("t1_head", {keyValid, head}, {1'b1, 8'h1C, 8'h41, 1'b0, 1'b0});
        check("t1_count", fifoCount, 1);
        drain();

        // extended release and plain release
        send_frame(8'hE0, 0, 1'b0);
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h75, 0, 1'b0);
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1C, 0, 1'b0);
        settle();
        check("t2_count", fifoCount, 2);
        check("t2_head", head, {8'h75, 8'h00, 1'b1, 1'b1});
        check("t2_model_pin", mq[1], {8'h1C, 8'h41, 1'b1, 1'b0});
        drain();

        // parity error then good frame
        send_frame(8'h1C, 1, 1'b0);
        settle();
        check("t3_parity_pulse", got_par, 1);
        check("t3_no_push", fifoCount, 0);
        send_frame(8'h16, 0, 1'b0);
        settle();
        check("t3_ascii_1", keyAscii, 8'h31);
        drain();

        // stop bit error, timeout, recovery
        send_frame(8'h1C, 2, 1'b0);
        settle();
        check("t4_stop_err", got_frm, 1);
        send_partial(5);
        repeat (TMO + 40) @(posedge clk);
        #1;
        exp_frm++; m_ext = 1'b0; m_rel = 1'b0;
        check("t4_timeout_err", got_frm, 2);
        send_frame(8'h45, 0, 1'b0);
        settle();
        check("t4_recover_ascii_0", {keyValid, keyCode, keyAscii}, {1'b1, 8'h45, 8'h30});
        check_counts("t4");
        drain();

        // overflow by one
        ovf0 = got_ovf;
        for (int i = 0; i <= DEPTH; i++) send_frame(LETTERS[i], 0, 1'b0);
        settle();
        check("t5_count_full", fifoCount, 16);
        check("t5_one_overflow", got_ovf - ovf0, 1);
        drain();
        check_counts("t5");

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) send_frame(DIGITS[i % 10], 0, 1'b0);
        settle();
        ovf0 = got_ovf;
        send_frame(8'h29, 0, 1'b1);
        settle();
        check("t6_count_full", fifoCount, 16);
        check("t6_no_overflow", got_ovf - ovf0, 0);

        // reset in the middle of a frame
        send_partial(5);
        rstN = 1'b0;
        #1;
        mq.delete(); m_ext = 1'b0; m_rel = 1'b0;
        check("t6_reset_outputs", {keyValid, keyCode, keyAscii, keyRelease, keyExtended,
                                   fifoCount, parityErr, frameErr, overflow}, 0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_frame(8'h5A, 0, 1'b0);
        settle();
        check("t6_after_reset", {fifoCount, keyCode, keyAscii}, {5'd1, 8'h5A, 8'h0D});
        drain();

        // randomized traffic
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0:       c = 8'hE0;
                1:       c = 8'hF0;
                2:       c = LETTERS[$urandom_range(0, 25)];
                3:       c = DIGITS[$urandom_range(0, 9)];
                default: c = 8'($urandom_range(0, 255));
            endcase
            kind = $urandom_range(0, 9);
            kind = (kind == 0) ? 1 : (kind == 1) ? 2 : 0;
            send_frame(c, kind, 1'b0);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 keyReady = 1'b0;
        drain();
        check_counts("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
